// File: rtl/player_pkg.sv
// Shared game-state encodings and the per-player FSM type for multi_player_stats.
package player_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_PLAY1 = 4'd1;
  localparam logic [3:0] ST_PLAY2 = 4'd2;
  localparam logic [3:0] ST_PLAY3 = 4'd3;
  localparam logic [3:0] ST_PLAY4 = 4'd4;
  localparam logic [3:0] ST_FAIL  = 4'd5;

  typedef enum logic {
    P_ALIVE = 1'b0,
    P_DEAD  = 1'b1
  } player_state_t;

  function automatic logic is_play(input logic [3:0] s);
    return (s == ST_PLAY1) || (s == ST_PLAY2) || (s == ST_PLAY3) || (s == ST_PLAY4);
  endfunction

  // Codes 6-15 behave like the failure screen.
  function automatic logic is_clear(input logic [3:0] s);
    return (s == ST_IDLE) || (s >= ST_FAIL);
  endfunction

endpackage

// File: rtl/money_bcd.sv
// Splits a money value (0..99) into decimal tens and ones digits.
module money_bcd #(
  parameter int MONEY_W = 7
) (
  input  logic [MONEY_W-1:0] bin,
  output logic [3:0]         tens,
  output logic [3:0]         ones
);

  always_comb begin
    tens = 4'(bin / MONEY_W'(10));
    ones = 4'(bin % MONEY_W'(10));
  end

endmodule

// File: rtl/multi_player_stats.sv
// Per-player life/money tracker with fail FSM and BCD readout of a selected player.
// Optional damage regeneration is built when PLAYER_REGEN_EN is defined.
module multi_player_stats
  import player_pkg::*;
#(
  parameter int N_PLAYERS    = 2,
  parameter int LIFE_MAX     = 10,
  parameter int MONEY_W      = 7,
  parameter int MONEY_MAX    = 99,
  parameter int MONEY_INIT   = 20,
  parameter int TICKET_COST  = 10,
  parameter int FAIL_PENALTY = 5,
  parameter int INVULN_CYC   = 4,
  parameter int REGEN_PERIOD = 1000,
  localparam int SEL_W       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     state,
  input  logic [N_PLAYERS-1:0]           damage,
  input  logic [N_PLAYERS-1:0]           hit,
  input  logic [N_PLAYERS-1:0]           ticket,
  input  logic [SEL_W-1:0]               sel,
  output logic [N_PLAYERS-1:0]           fail,
  output logic                           all_fail,
  output logic [N_PLAYERS*LIFE_MAX-1:0]  life,
  output logic [N_PLAYERS*MONEY_W-1:0]   money,
  output logic [3:0]                     bcd_tens,
  output logic [3:0]                     bcd_ones
);

  localparam int CNT_W = $clog2(LIFE_MAX + 1);
  localparam int INV_W = (INVULN_CYC > 0) ? $clog2(INVULN_CYC + 1) : 1;

  logic play, clr, frozen;

  always_comb begin
    play   = is_play(state);
    clr    = is_clear(state);
    frozen = (state >= ST_FAIL);
  end

  logic [MONEY_W-1:0] sel_chain [N_PLAYERS+1];
  assign sel_chain[0] = '0;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_player
    player_state_t      st_q, st_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INV_W-1:0]   inv_q, inv_d;
    logic [MONEY_W-1:0] money_q, money_d;
    logic               fail_q;
    logic               accept, dying, regen_fire;

`ifdef PLAYER_REGEN_EN
    localparam int RG_W = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
    logic [RG_W-1:0] rg_q, rg_d;

    // Accepted damage restarts the period, so it always beats a regen tick.
    always_comb begin
      rg_d       = '0;
      regen_fire = 1'b0;
      if (play && st_q == P_ALIVE && cnt_q != '0 && !accept) begin
        if (rg_q == RG_W'(REGEN_PERIOD - 1)) regen_fire = 1'b1;
        else                                 rg_d = rg_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rg_q <= '0;
      else     rg_q <= rg_d;
    end
`else
    assign regen_fire = 1'b0;
`endif

    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      inv_d   = inv_q;
      money_d = money_q;
      dying   = 1'b0;
      accept  = play && (st_q == P_ALIVE) && (inv_q == '0) && damage[g];

      if (clr) begin
        cnt_d = '0;
        inv_d = '0;
      end else if (accept) begin
        if (cnt_q != CNT_W'(LIFE_MAX)) cnt_d = cnt_q + 1'b1;
        inv_d = INV_W'(INVULN_CYC);
        dying = (cnt_d == CNT_W'(LIFE_MAX));
      end else begin
        if (inv_q != '0) inv_d = inv_q - 1'b1;
        if (regen_fire)  cnt_d = cnt_q - 1'b1;
      end

      case (st_q)
        P_ALIVE: if (dying) st_d = P_DEAD;
        P_DEAD:  if (clr)   st_d = P_ALIVE;
        default: st_d = P_ALIVE;
      endcase

      if (dying)
        money_d = (money_q > MONEY_W'(FAIL_PENALTY)) ? money_q - MONEY_W'(FAIL_PENALTY) : '0;
      else if (ticket[g] && !frozen)
        money_d = (money_q > MONEY_W'(TICKET_COST)) ? money_q - MONEY_W'(TICKET_COST) : '0;
      else if (hit[g] && play && st_q == P_ALIVE && money_q < MONEY_W'(MONEY_MAX))
        money_d = money_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q    <= P_ALIVE;
        cnt_q   <= '0;
        inv_q   <= '0;
        money_q <= MONEY_W'(MONEY_INIT);
        fail_q  <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        inv_q   <= inv_d;
        money_q <= money_d;
        fail_q  <= (st_d == P_DEAD);
      end
    end

    assign fail[g]                           = fail_q;
    assign money[g*MONEY_W +: MONEY_W]       = money_q;
    assign life[g*LIFE_MAX +: LIFE_MAX]      = (state == ST_IDLE) ? '0 : ({LIFE_MAX{1'b1}} >> cnt_q);
    assign sel_chain[g+1]                    = (sel == SEL_W'(g)) ? money_q : sel_chain[g];
  end

  assign all_fail = &fail;

  money_bcd #(.MONEY_W(MONEY_W)) u_bcd (
    .bin  (sel_chain[N_PLAYERS]),
    .tens (bcd_tens),
    .ones (bcd_ones)
  );

endmodule

// File: tb/tb_multi_player_stats.sv
// Self-checking bench for multi_player_stats (2 players, default costs, REGEN_PERIOD 8).
module tb_multi_player_stats;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  state;
  logic [1:0]  damage, hit, ticket;
  logic        sel;
  logic [1:0]  fail;
  logic        all_fail;
  logic [19:0] life;
  logic [13:0] money;
  logic [3:0]  bcd_tens, bcd_ones;

  int checks = 0;
  int errors = 0;

  multi_player_stats #(
    .N_PLAYERS(2), .LIFE_MAX(10), .MONEY_W(7), .MONEY_MAX(99), .MONEY_INIT(20),
    .TICKET_COST(10), .FAIL_PENALTY(5), .INVULN_CYC(4), .REGEN_PERIOD(8)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .damage(damage), .hit(hit), .ticket(ticket),
    .sel(sel), .fail(fail), .all_fail(all_fail), .life(life), .money(money),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] m0, m1;
    logic [1:0] fl;
    logic [3:0] tens, ones;
    logic [9:0] l0, l1;
  } exp_t;

  typedef struct {
    logic [3:0] st;
    logic [1:0] hit_v, tkt_v;
    logic       s;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[15];

  function automatic logic [9:0] therm(input int n);
    return 10'((32'd1 << n) - 32'd1);
  endfunction

  function automatic exp_t mk(input logic [6:0] m0, input logic [6:0] m1, input logic [1:0] fl,
                              input logic s, input logic [9:0] l0, input logic [9:0] l1);
    exp_t e;
    logic [6:0] m;
    m = s ? m1 : m0;
    e.m0 = m0; e.m1 = m1; e.fl = fl; e.l0 = l0; e.l1 = l1;
    e.tens = 4'(m / 7'd10);
    e.ones = 4'(m % 7'd10);
    return e;
  endfunction

  function automatic vec_t mv(input logic [3:0] st, input logic [1:0] h, input logic [1:0] t,
                              input logic s, input logic [6:0] m0, input logic [6:0] m1);
    vec_t v;
    logic [9:0] l;
    l = (st == 4'd0) ? 10'h000 : 10'h3ff;
    v.st = st; v.hit_v = h; v.tkt_v = t; v.s = s;
    v.e = mk(m0, m1, 2'b00, s, l, l);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    check("money0",   32'(money[6:0]),   32'(e.m0));
    check("money1",   32'(money[13:7]),  32'(e.m1));
    check("fail",     32'(fail),         32'(e.fl));
    check("all_fail", 32'(all_fail),     32'(&e.fl));
    check("bcd_tens", 32'(bcd_tens),     32'(e.tens));
    check("bcd_ones", 32'(bcd_ones),     32'(e.ones));
    check("life0",    32'(life[9:0]),    32'(e.l0));
    check("life1",    32'(life[19:10]),  32'(e.l1));
  endtask

  task automatic step(input exp_t e);
    sb.push_back(e);
    tick();
    compare_front();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m;
    state = 4'd0; damage = '0; hit = '0; ticket = '0; sel = 1'b0;

    tbl[0]  = mv(4'd1, 2'b01, 2'b00, 1'b0, 7'd21, 7'd20);
    tbl[1]  = mv(4'd1, 2'b01, 2'b00, 1'b0, 7'd22, 7'd20);
    tbl[2]  = mv(4'd1, 2'b01, 2'b00, 1'b0, 7'd23, 7'd20);
    tbl[3]  = mv(4'd1, 2'b01, 2'b00, 1'b0, 7'd24, 7'd20);
    tbl[4]  = mv(4'd1, 2'b01, 2'b00, 1'b0, 7'd25, 7'd20);
    tbl[5]  = mv(4'd1, 2'b10, 2'b00, 1'b1, 7'd25, 7'd21);
    tbl[6]  = mv(4'd1, 2'b11, 2'b01, 1'b0, 7'd15, 7'd22);
    tbl[7]  = mv(4'd0, 2'b00, 2'b11, 1'b1, 7'd5,  7'd12);
    tbl[8]  = mv(4'd0, 2'b00, 2'b01, 1'b0, 7'd0,  7'd12);
    tbl[9]  = mv(4'd0, 2'b11, 2'b00, 1'b1, 7'd0,  7'd12);
    tbl[10] = mv(4'd5, 2'b11, 2'b11, 1'b1, 7'd0,  7'd12);
    tbl[11] = mv(4'd9, 2'b00, 2'b10, 1'b1, 7'd0,  7'd12);
    tbl[12] = mv(4'd4, 2'b00, 2'b10, 1'b1, 7'd0,  7'd2);
    tbl[13] = mv(4'd2, 2'b10, 2'b10, 1'b1, 7'd0,  7'd0);
    tbl[14] = mv(4'd3, 2'b10, 2'b00, 1'b1, 7'd0,  7'd1);

    rst = 1'b1;
    tick();
    tick();
    sb.push_back(mk(7'd20, 7'd20, 2'b00, 1'b0, 10'h000, 10'h000));
    compare_front();
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      state = tbl[i].st; hit = tbl[i].hit_v; ticket = tbl[i].tkt_v; sel = tbl[i].s; damage = '0;
      step(tbl[i].e);
    end

    // player 1: climb to 7, ticket beats hit and floors at 0, then saturate at 99
    state = 4'd1; sel = 1'b1; ticket = '0; hit = 2'b10;
    repeat (6) tick();
    check("money1_at7", 32'(money[13:7]), 32'd7);
    ticket = 2'b10;
    tick();
    check("ticket_floor", 32'(money[13:7]), 32'd0);
    ticket = '0;
    repeat (105) tick();
    check("money1_sat", 32'(money[13:7]), 32'd99);
    repeat (3) tick();
    step(mk(7'd0, 7'd99, 2'b00, 1'b1, 10'h3ff, 10'h3ff));

    // player 0 takes continuous damage with hits; invulnerability spaces accepted hits 5 apart
    do_reset();
    state = 4'd1; sel = 1'b0; damage = 2'b01; hit = 2'b01; ticket = '0;
    for (int k = 1; k <= 46; k++) begin
      m = (k < 46) ? 20 + k : 60;
      step(mk(7'(m), 7'd20, (k == 46) ? 2'b01 : 2'b00, 1'b0, therm(10 - ((k - 1) / 5 + 1)), 10'h3ff));
    end
    repeat (3) step(mk(7'd60, 7'd20, 2'b01, 1'b0, 10'h000, 10'h3ff));

    damage = 2'b10; hit = '0;
    repeat (46) tick();
    step(mk(7'd60, 7'd15, 2'b11, 1'b0, 10'h000, 10'h000));

    // failure screen revives both, clears damage, ignores tickets
    state = 4'd5; damage = '0; ticket = 2'b11;
    step(mk(7'd60, 7'd15, 2'b00, 1'b0, 10'h3ff, 10'h3ff));
    step(mk(7'd60, 7'd15, 2'b00, 1'b0, 10'h3ff, 10'h3ff));
    ticket = '0; state = 4'd0;
    #1;
    check("life_idle", 32'(life), 32'd0);

    // asynchronous reset in the middle of an invulnerability window
    state = 4'd1; damage = 2'b01; hit = 2'b01;
    step(mk(7'd61, 7'd15, 2'b00, 1'b0, therm(9), 10'h3ff));
    #2 rst = 1'b1;
    #1;
    check("rst_money0", 32'(money[6:0]), 32'd20);
    check("rst_money1", 32'(money[13:7]), 32'd20);
    check("rst_life0",  32'(life[9:0]), 32'(therm(10)));
    check("rst_fail",   32'(fail), 32'd0);
    rst = 1'b0;
    step(mk(7'd21, 7'd20, 2'b00, 1'b0, therm(9), 10'h3ff));

`ifdef PLAYER_REGEN_EN
    do_reset();
    state = 4'd2; damage = 2'b01; hit = '0;
    repeat (11) tick();
    check("regen_cnt3", 32'(life[9:0]), 32'(therm(7)));
    damage = '0;
    repeat (7) tick();
    check("regen_hold", 32'(life[9:0]), 32'(therm(7)));
    tick();
    check("regen_dec", 32'(life[9:0]), 32'(therm(8)));
    hit = 2'b01;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("regen_rst_life",  32'(life[9:0]), 32'(therm(10)));
    check("regen_rst_money", 32'(money[6:0]), 32'd20);
    rst = 1'b0;
    hit = '0;
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_player_stats.md
MULTI_PLAYER_STATS -- requirements
Module: multi_player_stats

Interface
REQ-001 Parameter N_PLAYERS, default 2: number of independent player channels (1..8).
REQ-002 Parameter LIFE_MAX, default 10: hits to fail; also life bar width per player.
REQ-003 Parameter MONEY_W, default 7: money register width per player.
REQ-004 Parameters MONEY_MAX 99, MONEY_INIT 20, TICKET_COST 10, FAIL_PENALTY 5: money limits and costs; MONEY_MAX SHALL be at most 99.
REQ-005 Parameters INVULN_CYC 4 and REGEN_PERIOD 1000: post-damage immunity length and regen interval, both in clk cycles.
REQ-006 clk  in  1  single system clock; every register is on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 state  in  4  game state: 0 idle, 1-4 play levels, 5 failure screen, 6-15 treated as 5.
REQ-009 damage, hit, ticket  in  N_PLAYERS each  one bit per player, sampled each cycle.
REQ-010 sel  in  clog2(N_PLAYERS), minimum 1  player selected for BCD output.
REQ-011 fail  out  N_PLAYERS  registered per-player fail flag.
REQ-012 all_fail  out  1  AND of all fail bits.
REQ-013 life  out  N_PLAYERS*LIFE_MAX  per-player thermometer life bar; player i occupies slice i.
REQ-014 money  out  N_PLAYERS*MONEY_W  per-player money value.
REQ-015 bcd_tens, bcd_ones  out  4 each  decimal digits of money[sel]; both 0 when sel >= N_PLAYERS.

Function
REQ-016 Each player SHALL run a 2-state FSM: ALIVE and DEAD.
REQ-017 ALIVE->DEAD SHALL occur in the cycle its damage count reaches LIFE_MAX; fail SHALL assert one cycle later and hold while DEAD.
REQ-018 DEAD->ALIVE SHALL occur when state is 0 or 5; fail SHALL deassert on that cycle.
REQ-019 A damage pulse SHALL count only under all of: state 1-4, ALIVE, invulnerability counter 0. The damage count increments by 1, saturates at LIFE_MAX, and the counter loads INVULN_CYC.
REQ-020 A nonzero invulnerability counter SHALL decrement by 1 every cycle; damage pulses arriving while it is nonzero SHALL be dropped.
REQ-021 The damage count and invulnerability counter SHALL clear to 0 whenever state is 0 or 5.
REQ-022 life slice i SHALL contain (LIFE_MAX - count) low-order ones and the rest zeros; all life bits SHALL be 0 when state is 0.
REQ-023 Money SHALL change by at most one update per cycle, with priority: fail penalty > ticket > hit.
REQ-024 Fail penalty: one-shot on the ALIVE->DEAD cycle; subtract FAIL_PENALTY, saturating at 0.
REQ-025 Ticket: in state 0-4, subtract TICKET_COST, saturating at 0 (money <= TICKET_COST gives 0).
REQ-026 Hit: in state 1-4 while ALIVE, add 1, saturating at MONEY_MAX.
REQ-027 In state 5, money SHALL be frozen and ticket/hit SHALL be ignored.
REQ-028 BCD outputs SHALL be combinational from the registered money: tens = money/10, ones = money mod 10.
REQ-029 Players SHALL be fully independent; simultaneous events on different channels SHALL all take effect in the same cycle.

Reset
REQ-030 rst SHALL force asynchronously: FSM ALIVE, damage count 0, invulnerability counter 0, money MONEY_INIT, fail 0, regen counter 0.
REQ-031 Reset asserted mid-operation SHALL discard any pending penalty or regen event; the first post-reset edge SHALL behave as from power-up.

Configuration
REQ-032 Macro PLAYER_REGEN_EN defined: a per-player counter SHALL count in state 1-4 while ALIVE with count > 0. On reaching REGEN_PERIOD it SHALL decrement the damage count by 1 and restart. An accepted damage on the same cycle SHALL win and also restart the counter.
REQ-033 Macro PLAYER_REGEN_EN undefined: no regen logic is synthesised and the damage count never decrements except by REQ-021.

Structure
REQ-034 Package player_pkg SHALL hold the game-state constants (ST_IDLE=0, ST_PLAY1..ST_PLAY4=1..4, ST_FAIL=5) and the player FSM enum typedef.
REQ-035 Sub-module money_bcd SHALL perform the binary-to-BCD split; it is instantiated once, fed by the sel mux.

Verification
REQ-036 Reset, then state=1 and hit[0] held 5 cycles -> money[0]=25, bcd_tens=2, bcd_ones=5 with sel=0.
REQ-037 state=1, damage[0] pulsed every cycle -> count rises once per 5 cycles (INVULN_CYC=4); after the 10th accepted hit fail[0]=1 one cycle later and money[0] drops by exactly 5, once.
REQ-038 money[1]=99 with hit[1] held -> stays 99; money[1]=7 with ticket[1] -> 0; same cycle as hit[1] -> ticket wins.
REQ-039 Both players failed -> all_fail=1; state=5 -> fail=0 on both, life cleared, money unchanged despite ticket pulses.
REQ-040 With PLAYER_REGEN_EN and REGEN_PERIOD=8, count=3 in state 2 with no damage -> count=2 after 8 cycles; rst asserted mid-period -> count 0 and money 20 immediately.
